// File: rtl/z80_bus_responder.sv
// Z80 bus target: serves a RAM window with programmable wait states, a 4-register
// I/O block (scratch, vector, cycle counter, status) and interrupt-acknowledge vector fetches.
module z80_bus_responder #(
  parameter logic [15:0] MEM_BASE    = 16'h0000,
  parameter int          MEM_AW      = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [7:0]  IO_BASE     = 8'h40,
  parameter logic [7:0]  INT_VECTOR  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [7:0]  dout_cpu,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        rfsh_n,
  output logic [7:0]  din_cpu,
  output logic        din_oe,
  output logic        wait_n,
  output logic        irq_n,
  input  logic        irq_src
);

  localparam int         MEM_DEPTH = 1 << MEM_AW;
  localparam logic [2:0] WS        = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE, S_MWAIT, S_MRD, S_MWR, S_IORD, S_IOWR, S_INTA, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_armed;
  logic [MEM_AW-1:0] r_maddr;
  logic              r_is_rd;
  logic [2:0]        r_cnt;
  logic [1:0]        r_port;
  logic [7:0]        r_io_rdata;
  logic [7:0]        r_scratch;
  logic [7:0]        r_vector;
  logic [7:0]        r_cyc;
  logic              r_pending;
  logic              r_irq_prev;
  logic [7:0]        r_ram_rdata;
  logic [7:0]        r_mem [MEM_DEPTH];

  logic [15:0] w_offset;
  logic        w_in_win;
  logic        w_mem_hit;
  logic        w_io_hit;
  logic        w_inta;
  logic        w_strobe;
  logic        w_start_inta;
  logic        w_start_mem;
  logic        w_start_io;
  logic        w_io_wr;
  logic        w_irq_clr;
  logic        w_irq_rise;
  logic [7:0]  w_io_mux;

  assign w_offset  = addr - MEM_BASE;
  assign w_in_win  = {1'b0, w_offset} < 17'(MEM_DEPTH);
  assign w_mem_hit = !mreq_n & rfsh_n & w_in_win;
  assign w_io_hit  = !iorq_n & m1_n & (addr[7:2] == IO_BASE[7:2]);
  assign w_inta    = !iorq_n & !m1_n;
  assign w_strobe  = !rd_n | !wr_n;

  // r_armed blocks a strobe that was already low when IDLE was (re)entered.
  assign w_start_inta = (r_state == S_IDLE) & r_armed & w_inta;
  assign w_start_mem  = (r_state == S_IDLE) & r_armed & !w_inta & w_mem_hit & w_strobe;
  assign w_start_io   = (r_state == S_IDLE) & r_armed & !w_inta & !w_mem_hit & w_io_hit & w_strobe;

  assign w_io_wr    = (r_state == S_IOWR);
  assign w_irq_rise = irq_src & !r_irq_prev;
  assign w_irq_clr  = w_start_inta | (w_io_wr & (r_port == 2'd3) & dout_cpu[0]);
  assign irq_n      = !r_pending;

  always_comb begin
    w_io_mux = 8'h00;
    case (addr[1:0])
      2'd0:    w_io_mux = r_scratch;
      2'd1:    w_io_mux = r_vector;
      2'd2:    w_io_mux = r_cyc;
      default: w_io_mux = {7'b0, r_pending};
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    din_cpu      = 8'h00;
    din_oe       = 1'b0;
    wait_n       = !((r_state == S_MWAIT) && (r_cnt != 3'd0));
    case (r_state)
      S_IDLE: begin
        if (w_start_inta)     w_state_next = S_INTA;
        else if (w_start_mem) w_state_next = S_MWAIT;
        else if (w_start_io)  w_state_next = !rd_n ? S_IORD : S_IOWR;
      end
      S_MWAIT: if (r_cnt == 3'd0) w_state_next = r_is_rd ? S_MRD : S_MWR;
      S_MRD: begin
        din_cpu = r_ram_rdata;
        din_oe  = 1'b1;
        if (rd_n | mreq_n) w_state_next = S_DONE;
      end
      S_MWR: w_state_next = S_DONE;
      S_IORD: begin
        din_cpu = r_io_rdata;
        din_oe  = 1'b1;
        if (rd_n | iorq_n) w_state_next = S_DONE;
      end
      S_IOWR: w_state_next = S_DONE;
      S_INTA: begin
        din_cpu = r_vector;
        din_oe  = 1'b1;
        if (iorq_n) w_state_next = S_DONE;
      end
      S_DONE: if (mreq_n & iorq_n) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_armed    <= 1'b0;
      r_maddr    <= '0;
      r_is_rd    <= 1'b0;
      r_cnt      <= 3'd0;
      r_port     <= 2'd0;
      r_io_rdata <= 8'h00;
      r_scratch  <= 8'h00;
      r_vector   <= INT_VECTOR;
      r_cyc      <= 8'h00;
      r_pending  <= 1'b0;
      r_irq_prev <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_armed    <= (mreq_n & iorq_n) | (r_armed & (r_state == S_IDLE) & (w_state_next == S_IDLE));
      r_irq_prev <= irq_src;
      // A new edge wins over a coincident clear so no interrupt is lost.
      if (w_irq_rise)     r_pending <= 1'b1;
      else if (w_irq_clr) r_pending <= 1'b0;
      if (w_io_wr && r_port == 2'd2) r_cyc <= 8'h00;
      else                           r_cyc <= r_cyc + 8'd1;
      if (w_io_wr && r_port == 2'd0) r_scratch <= dout_cpu;
      if (w_io_wr && r_port == 2'd1) r_vector  <= dout_cpu;
      if (w_start_mem) begin
        r_maddr <= w_offset[MEM_AW-1:0];
        r_is_rd <= !rd_n;
        r_cnt   <= WS;
      end else if (r_state == S_MWAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_start_io) begin
        r_port     <= addr[1:0];
        r_io_rdata <= w_io_mux;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_MWR) r_mem[r_maddr] <= dout_cpu;
    if (w_start_mem)      r_ram_rdata    <= r_mem[w_offset[MEM_AW-1:0]];
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Scoreboarded bench for z80_bus_responder: dut0 (base 0000, one wait state) and
// dut1 (base AA00, no wait states) share one Z80 bus.
module tb_z80_bus_responder;

  localparam logic [7:0] IOB = 8'h40;
  localparam int         WS0 = 1;
  localparam int         WS1 = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [7:0]  dout_cpu;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, irq_src;
  logic [7:0]  din0, din1;
  logic        oe0, oe1, wait0, wait1, irq0, irq1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_q[$];

  z80_bus_responder #(.MEM_BASE(16'h0000), .MEM_AW(8), .WAIT_STATES(WS0), .IO_BASE(IOB), .INT_VECTOR(8'hFF)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .dout_cpu(dout_cpu),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
    .din_cpu(din0), .din_oe(oe0), .wait_n(wait0), .irq_n(irq0), .irq_src(irq_src)
  );

  z80_bus_responder #(.MEM_BASE(16'hAA00), .MEM_AW(8), .WAIT_STATES(WS1), .IO_BASE(IOB), .INT_VECTOR(8'hFF)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .dout_cpu(dout_cpu),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
    .din_cpu(din1), .din_oe(oe1), .wait_n(wait1), .irq_n(irq1), .irq_src(irq_src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int got, input int expv);
    n_vec++;
    if (got != expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic int oe_of(input int s);
    return (s == 0) ? int'(oe0) : int'(oe1);
  endfunction
  function automatic int wait_of(input int s);
    return (s == 0) ? int'(wait0) : int'(wait1);
  endfunction
  function automatic int din_of(input int s);
    return (s == 0) ? int'(din0) : int'(din1);
  endfunction
  function automatic int ws_of(input int s);
    return (s == 0) ? WS0 : WS1;
  endfunction

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic mem_rd(input int s, input logic [15:0] a, input bit hit, input int e,
                        input bit m1, input bit also_wr);
    int k, nwait, expv;
    bit seen;
    @(negedge clk);
    addr = a; dout_cpu = 8'hAA; mreq_n = 1'b0; rd_n = 1'b0; m1_n = !m1; wr_n = !also_wr;
    if (hit) exp_q.push_back(e);
    seen = 0; nwait = 0; k = 0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (wait_of(s) == 0) nwait++;
      if (oe_of(s) != 0) seen = 1;
    end
    if (hit) begin
      check_val("rd_seen", int'(seen), 1);
      if (exp_q.size() != 0) expv = exp_q.pop_front(); else expv = -1;
      if (seen) begin
        check_val("rd_data", din_of(s), expv);
        check_val("rd_latency", k - 1, ws_of(s) + 1);
        check_val("rd_wait_cycles", nwait, ws_of(s));
        @(negedge clk);
        check_val("rd_hold_oe", oe_of(s), 1);
      end
    end else begin
      check_val("miss_oe", int'(seen), 0);
      check_val("miss_wait", nwait, 0);
    end
    bus_idle();
    @(negedge clk);
    check_val("rd_release_oe", oe_of(s), 0);
    @(negedge clk);
    $display("mem_rd dut%0d addr=%h hit=%0d data=%h", s, a, hit, din_of(s));
  endtask

  task automatic mem_wr(input int s, input logic [15:0] a, input logic [7:0] d, input bit hit);
    int nwait, noe;
    @(negedge clk);
    addr = a; dout_cpu = d; mreq_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b0;
    nwait = 0; noe = 0;
    repeat (ws_of(s) + 5) begin
      @(negedge clk);
      if (wait_of(s) == 0) nwait++;
      if (oe_of(s) != 0) noe++;
    end
    check_val("wr_wait_cycles", nwait, hit ? ws_of(s) : 0);
    check_val("wr_oe", noe, 0);
    bus_idle();
    repeat (2) @(negedge clk);
    $display("mem_wr dut%0d addr=%h data=%h hit=%0d", s, a, d, hit);
  endtask

  task automatic io_wr(input logic [1:0] p, input logic [7:0] d, input bit irq_edge);
    @(negedge clk);
    addr = {8'h12, IOB[7:2], p}; dout_cpu = d; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    if (irq_edge) irq_src = 1'b1;
    @(negedge clk);
    bus_idle();
    repeat (2) @(negedge clk);
    $display("io_wr port=%0d data=%h irq_edge=%0d", p, d, irq_edge);
  endtask

  // e < 0: value not predicted; t_ref >= 0: expect v_ref advanced by elapsed cycles.
  task automatic io_rd(input logic [1:0] p, input int e, input int t_ref, input int v_ref,
                       output int v, output int t);
    int k, expv;
    bit seen, chk;
    @(negedge clk);
    addr = {8'h34, IOB[7:2], p}; iorq_n = 1'b0; rd_n = 1'b0;
    t = cyc;
    chk = (e >= 0) || (t_ref >= 0);
    if (t_ref >= 0) exp_q.push_back((v_ref + t - t_ref) % 256);
    else if (e >= 0) exp_q.push_back(e);
    seen = 0; k = 0;
    while (!seen && k < 8) begin
      @(negedge clk);
      k++;
      if (oe0) seen = 1;
    end
    v = int'(din0);
    check_val("io_seen", int'(seen), 1);
    check_val("io_latency", k, 1);
    if (chk) begin
      if (exp_q.size() != 0) expv = exp_q.pop_front(); else expv = -1;
      check_val("io_data", v, expv);
    end
    bus_idle();
    repeat (2) @(negedge clk);
    $display("io_rd port=%0d data=%h", p, v);
  endtask

  initial begin : stim
    int v1, v2, t1, t2, noe, nw, k, expv;
    bit seen;
    bus_idle();
    addr = 16'h0000; dout_cpu = 8'h00; irq_src = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_din", int'(din0), 0);
    check_val("rst_oe", int'(oe0), 0);
    check_val("rst_wait", int'(wait0), 1);
    check_val("rst_irq", int'(irq0), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    io_rd(2'd1, 8'hFF, -1, 0, v1, t1);
    io_rd(2'd0, 8'h00, -1, 0, v1, t1);
    io_rd(2'd3, 8'h00, -1, 0, v1, t1);

    mem_wr(0, 16'h0000, 8'h3E, 1);
    mem_wr(0, 16'h0001, 8'h2A, 1);
    mem_wr(0, 16'h0002, 8'h00, 1);
    mem_rd(0, 16'h0000, 1, 8'h3E, 1, 0);
    mem_rd(0, 16'h0001, 1, 8'h2A, 0, 0);
    mem_rd(0, 16'h0002, 1, 8'h00, 0, 0);

    mem_wr(0, 16'h0005, 8'h55, 1);
    mem_rd(0, 16'h0005, 1, 8'h55, 0, 1);
    mem_rd(0, 16'h0005, 1, 8'h55, 0, 0);
    mem_wr(0, 16'h00FF, 8'h5A, 1);
    mem_rd(0, 16'h00FF, 1, 8'h5A, 0, 0);
    mem_rd(0, 16'h0100, 0, 0, 0, 0);

    mem_wr(1, 16'hAA20, 8'h1D, 1);
    mem_rd(1, 16'hAA20, 1, 8'h1D, 0, 0);
    mem_wr(1, 16'hAB20, 8'h77, 0);
    mem_rd(1, 16'hAB20, 0, 0, 0, 0);
    mem_wr(1, 16'hAAFF, 8'hE1, 1);
    mem_rd(1, 16'hAAFF, 1, 8'hE1, 0, 0);
    mem_rd(1, 16'hA9FF, 0, 0, 0, 0);

    @(negedge clk);
    addr = 16'h0001; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
    noe = 0; nw = 0;
    repeat (6) begin
      @(negedge clk);
      if (oe0) noe++;
      if (!wait0) nw++;
    end
    check_val("rfsh_oe", noe, 0);
    check_val("rfsh_wait", nw, 0);
    bus_idle();
    repeat (2) @(negedge clk);
    $display("refresh addr=0001 oe_cycles=%0d wait_cycles=%0d", noe, nw);

    io_wr(2'd0, 8'h5C, 0);
    io_rd(2'd0, 8'h5C, -1, 0, v1, t1);
    io_wr(2'd1, 8'hC7, 0);
    io_rd(2'd1, 8'hC7, -1, 0, v1, t1);

    @(negedge clk); irq_src = 1'b1;
    @(negedge clk); check_val("irq_assert", int'(irq0), 0);
    irq_src = 1'b0;
    io_rd(2'd3, 8'h01, -1, 0, v1, t1);

    @(negedge clk); m1_n = 1'b0;
    @(negedge clk); iorq_n = 1'b0; exp_q.push_back(8'hC7);
    seen = 0; k = 0;
    while (!seen && k < 8) begin
      @(negedge clk);
      k++;
      if (oe0) seen = 1;
    end
    check_val("inta_seen", int'(seen), 1);
    if (exp_q.size() != 0) expv = exp_q.pop_front(); else expv = -1;
    check_val("inta_vector", int'(din0), expv);
    check_val("inta_irq_clear", int'(irq0), 1);
    bus_idle();
    repeat (2) @(negedge clk);
    check_val("inta_release_oe", int'(oe0), 0);
    $display("inta vector=%h irq_n=%0d", din0, irq0);

    io_wr(2'd3, 8'h01, 1);
    check_val("irq_edge_vs_clear", int'(irq0), 0);
    irq_src = 1'b0;
    io_wr(2'd3, 8'h01, 0);
    check_val("irq_port_clear", int'(irq0), 1);
    io_rd(2'd3, 8'h00, -1, 0, v1, t1);

    io_rd(2'd2, -1, -1, 0, v1, t1);
    repeat (6) @(negedge clk);
    io_rd(2'd2, 0, t1, v1, v2, t2);
    io_wr(2'd2, 8'h00, 0);
    io_rd(2'd2, -1, -1, 0, v1, t1);
    check_val("cnt_small_after_clear", int'(v1 < 8), 1);

    @(negedge clk);
    addr = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0;
    @(negedge clk);
    check_val("mwait_wait_low", int'(wait0), 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_wait", int'(wait0), 1);
    check_val("rst_mid_oe", int'(oe0), 0);
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("async reset during MWAIT wait_n=%0d din_oe=%0d", wait0, oe0);
    mem_rd(0, 16'h0000, 1, 8'h3E, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
